// File: rtl/fetch_pc_pkg.sv
// Shared constants for the fetch stage and its neighbours.
// CP0 and the other stages' exception checks reuse these, so that every stage
// agrees on the exception codes and on the default memory map.
//   exc_code_e : 5-bit exception codes written into the pipeline.
//   RESET_PC   : PC loaded on reset.
//   HANDLER_PC : exception/interrupt handler entry.
//   IM_BASE    : lowest legal instruction fetch address.
//   IM_END     : highest legal instruction fetch address (inclusive).
package fetch_pc_pkg;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4
  } exc_code_e;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_END     = 32'h0000_6FFC;

endpackage

// File: rtl/fetch_pc_if.sv
// Signal bundle between the fetch PC unit and the rest of the pipeline
// (CP0, D-stage control, instruction memory, F/D register).
//   master : the fetch unit; drives F_PC, F_Instr, F_ExcCode, F_BD.
//   slave  : the surrounding pipeline; drives requests, redirects, stall
//            and instruction memory read data.
interface fetch_pc_if;
  logic        Req;
  logic        ERET;
  logic [31:0] EPC;
  logic        STALL_EN_N;
  logic        D_Redirect;
  logic [31:0] D_Target;
  logic        D_IsBranchJump;
  logic [31:0] IM_RData;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic [4:0]  F_ExcCode;
  logic        F_BD;

  modport master (
    input  Req, ERET, EPC, STALL_EN_N, D_Redirect, D_Target, D_IsBranchJump,
           IM_RData,
    output F_PC, F_Instr, F_ExcCode, F_BD
  );

  modport slave (
    output Req, ERET, EPC, STALL_EN_N, D_Redirect, D_Target, D_IsBranchJump,
           IM_RData,
    input  F_PC, F_Instr, F_ExcCode, F_BD
  );
endinterface

// File: rtl/fetch_addr_check.sv
// Combinational instruction address check: flags a misaligned word address
// or one outside the [IM_BASE, IM_END] window (unsigned compares).
// Also instantiated by the D-stage jump-target check.
//   addr     : 32-bit byte address to check.
//   addr_err : 1 when addr is not a legal instruction fetch address.
module fetch_addr_check #(
  parameter logic [31:0] IM_BASE = fetch_pc_pkg::IM_BASE,
  parameter logic [31:0] IM_END  = fetch_pc_pkg::IM_END
) (
  input  logic [31:0] addr,
  output logic        addr_err
);

  logic misaligned;
  logic below_base;
  logic above_end;

  assign misaligned = |addr[1:0];
  assign below_base = (addr < IM_BASE);
  assign above_end  = (addr > IM_END);
  assign addr_err   = misaligned | below_base | above_end;

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage program counter of the 5-stage MIPS pipeline.
// Holds the fetch PC, selects the next PC (reset, exception entry, eret,
// stall, D-stage redirect, sequential), checks the fetch address and presents
// instruction / PC / exception code / delay-slot flag to the F/D register.
//   clk   : clock.
//   RESET : synchronous, active-high reset.
//   bus   : fetch_pc_if.master (requests and redirects in, F_* outputs out).
module fetch_pc #(
  parameter logic [31:0] RESET_PC   = fetch_pc_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = fetch_pc_pkg::HANDLER_PC,
  parameter logic [31:0] IM_BASE    = fetch_pc_pkg::IM_BASE,
  parameter logic [31:0] IM_END     = fetch_pc_pkg::IM_END
) (
  input  logic        clk,
  input  logic        RESET,
  fetch_pc_if.master  bus
);

  import fetch_pc_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        fetch_err;

  // Next-PC priority: exception entry beats eret, both beat stall; a stalled
  // redirect is dropped because the stalled D stage re-presents it.
  always_comb begin
    // NOTE: default first so every path assigns pc_next and no latch is inferred.
    pc_next = pc_q + 32'd4;
    if (bus.Req) begin
      pc_next = HANDLER_PC;
    end else if (bus.ERET) begin
      pc_next = bus.EPC;
    end else if (bus.STALL_EN_N) begin
      pc_next = pc_q;
    end else if (bus.D_Redirect) begin
      pc_next = bus.D_Target;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for registered state so all flops update on the same edge.
    if (RESET) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  fetch_addr_check #(
    .IM_BASE (IM_BASE),
    .IM_END  (IM_END)
  ) u_addr_check (
    .addr     (pc_q),
    .addr_err (fetch_err)
  );

  assign bus.F_PC      = pc_q;
  // A faulting fetch becomes a nop carrying AdEL; the bad address is never
  // corrected here, CP0 takes the exception when the nop reaches it.
  assign bus.F_Instr   = fetch_err ? 32'h0 : bus.IM_RData;
  assign bus.F_ExcCode = fetch_err ? EXC_ADEL : EXC_NONE;
  // F/D discards this fetch on Req/ERET; forcing 0 keeps it deterministic.
  assign bus.F_BD      = bus.D_IsBranchJump & ~(bus.Req | bus.ERET);

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: the stimulus process drives one cycle of
// inputs and queues the hand-computed F_* values for that cycle; a monitor
// samples the DUT on the falling edge and compares against the queue head.
module tb_fetch_pc;

  localparam logic [31:0] MEM_KEY = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  logic clk;
  logic RESET;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  fetch_pc_if bus ();

  fetch_pc dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.master)
  );

  // Instruction memory model: contents are a fixed function of the address.
  assign bus.IM_RData = bus.F_PC ^ MEM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One cycle: drive inputs, queue the expected outputs for this cycle,
  // then advance past the next rising edge.
  task automatic cyc(input logic rst, input logic req, input logic eret,
                     input logic [31:0] epc, input logic stall,
                     input logic redir, input logic [31:0] tgt,
                     input logic isbj, input logic [31:0] exp_pc,
                     input logic exp_adel, input logic exp_bd);
    exp_t e;
    RESET              = rst;
    bus.Req            = req;
    bus.ERET           = eret;
    bus.EPC            = epc;
    bus.STALL_EN_N     = stall;
    bus.D_Redirect     = redir;
    bus.D_Target       = tgt;
    bus.D_IsBranchJump = isbj;
    e.pc    = exp_pc;
    e.instr = exp_adel ? 32'h0 : (exp_pc ^ MEM_KEY);
    e.exc   = exp_adel ? 5'd4 : 5'd0;
    e.bd    = exp_bd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("F_PC",      bus.F_PC,              e.pc);
      check("F_Instr",   bus.F_Instr,           e.instr);
      check("F_ExcCode", {27'h0, bus.F_ExcCode}, {27'h0, e.exc});
      check("F_BD",      {31'h0, bus.F_BD},      {31'h0, e.bd});
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET              = 1'b1;
    bus.Req            = 1'b0;
    bus.ERET           = 1'b0;
    bus.EPC            = 32'h0;
    bus.STALL_EN_N     = 1'b0;
    bus.D_Redirect     = 1'b0;
    bus.D_Target       = 32'h0;
    bus.D_IsBranchJump = 1'b0;
    @(posedge clk);
    #1;

    //  rst req eret epc           stall redir tgt           isbj exp_pc        adel bd
    // Reset state, then free run.
    cyc(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3000, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3000, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3004, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3008, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_300C, 0, 0);
    // Stall + redirect holds; redirect taken once the stall drops.
    cyc(0, 0, 0, 32'h0,         1, 1, 32'h0000_3100, 0, 32'h0000_3010, 0, 0);
    cyc(0, 0, 0, 32'h0,         1, 1, 32'h0000_3100, 0, 32'h0000_3010, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 1, 32'h0000_3100, 0, 32'h0000_3010, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 1, 32'h0000_3020, 0, 32'h0000_3100, 0, 0);
    // Req + ERET + stall: handler wins, F_BD forced low.
    cyc(0, 1, 1, 32'h0000_3008, 1, 0, 32'h0,         1, 32'h0000_3020, 0, 0);
    // ERET to a misaligned EPC; F_BD forced low by ERET.
    cyc(0, 0, 1, 32'h0000_3006, 0, 0, 32'h0,         1, 32'h0000_4180, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3006, 1, 0);
    cyc(0, 0, 0, 32'h0,         0, 1, 32'h0000_6FF8, 0, 32'h0000_300A, 1, 0);
    // Upper boundary of the fetch window.
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_6FF8, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_6FFC, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 1, 32'h0000_2FFC, 0, 32'h0000_7000, 1, 0);
    // Just below the lower boundary.
    cyc(0, 0, 0, 32'h0,         0, 1, 32'h0000_3040, 0, 32'h0000_2FFC, 1, 0);
    // Delay-slot flag, then Req forces it low.
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3040, 0, 1);
    cyc(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3044, 0, 0);
    // Reset wins over a redirect during a stall.
    cyc(1, 0, 0, 32'h0,         1, 1, 32'h0000_5000, 0, 32'h0000_4180, 0, 0);
    // PC wrap-around past 2^32.
    cyc(0, 0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0000_3000, 0, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 0);
    // ERET during a stall still redirects.
    cyc(0, 0, 1, 32'h0000_3000, 1, 0, 32'h0,         0, 32'h0000_0000, 1, 0);
    cyc(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_3000, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Fetch-stage program-counter unit of the 5-stage MIPS pipeline.
- Holds the architectural fetch PC and selects the next PC from these sources: sequential, D-stage branch/jump redirect, exception handler entry, and EPC on `eret`.
- Checks the fetch address for address errors.
- Presents the instruction word, PC, exception code and delay-slot flag to the F/D pipeline register.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_3000`: PC loaded on reset.
- `HANDLER_PC`, `32'h0000_4180`: exception/interrupt handler entry.
- `IM_BASE`, `32'h0000_3000`: lowest legal fetch address.
- `IM_END`, `32'h0000_6FFC`: highest legal fetch address (inclusive).

Ports:
- `clk`, in, 1: clock.
- `RESET`, in, 1: synchronous, active-high reset.
- `Req`, in, 1: CP0 exception/interrupt request; forces handler entry.
- `ERET`, in, 1: `eret` decoded in D; redirects to `EPC`.
- `EPC`, in, 32: return address from CP0.
- `STALL_EN_N`, in, 1: 1 = hold PC (hazard stall); 0 = advance.
- `D_Redirect`, in, 1: taken branch or jump resolved in D.
- `D_Target`, in, 32: redirect target.
- `D_IsBranchJump`, in, 1: instruction in D is a branch/jump, whether taken or not.
- `IM_RData`, in, 32: instruction memory read data, combinational from `F_PC`.
- `F_PC`, out, 32: current fetch address; drives IM and the F/D register address input.
- `F_Instr`, out, 32: instruction to F/D; `32'h0` (nop) when a fetch exception is flagged.
- `F_ExcCode`, out, 5: `5'd4` (AdEL) on a fetch address error, else `5'd0`.
- `F_BD`, out, 1: the instruction in F sits in a branch delay slot.

## Operation
- PC register update at each `clk` edge, in strict priority order:
  1. `RESET`: PC ← `RESET_PC`.
  2. `Req`: PC ← `HANDLER_PC`. Applies regardless of stall.
  3. `ERET`: PC ← `EPC`. Applies regardless of stall. Control guarantees `ERET` is never asserted while the `eret` itself is stalled in D.
  4. `STALL_EN_N`: PC holds.
  5. `D_Redirect`: PC ← `D_Target`.
  6. Otherwise: PC ← PC + 4, modulo 2^32 with wrap-around; no carry out.
- Fetch address error: `F_PC[1:0] != 0`, or `F_PC < IM_BASE`, or `F_PC > IM_END` (unsigned compares).
  - On error: `F_ExcCode = 4`, `F_Instr = 0`.
  - On no error: `F_ExcCode = 0`, `F_Instr = IM_RData`.
- After a faulting fetch the PC keeps advancing by the normal rules. The faulting nop carries AdEL down the pipe until CP0 raises `Req`.
- `F_BD = D_IsBranchJump`. When `Req` or `ERET` is asserted, `F_BD` is forced to 0 in that cycle. The F/D register discards this fetch anyway; forcing 0 keeps the value deterministic.
- `eret` has no delay slot: the instruction fetched in the `ERET` cycle is discarded by F/D.

## Timing
- `F_PC` is registered. `F_Instr`, `F_ExcCode` and `F_BD` are combinational from `F_PC` and the inputs in the same cycle.
- Redirect latency: the target appears on `F_PC` the cycle after `D_Redirect`, `Req` or `ERET` is sampled.
- Reset values: `F_PC = RESET_PC`, `F_ExcCode = 0`, `F_Instr = IM_RData`, `F_BD = D_IsBranchJump`.
- Simultaneous events resolve by the priority list above:
  - `Req` + `ERET`: `HANDLER_PC`.
  - Stall + `D_Redirect`: hold; the redirect is re-presented next cycle by the stalled D stage.
  - `RESET` mid-stall or mid-redirect: `RESET_PC`.
- `EPC` is misaligned or out of range: the next cycle fetches it and flags AdEL. It is never silently corrected.

## Structure
- Shared package: exception code constants (`EXC_NONE = 0`, `EXC_ADEL = 4`) and the default address constants `RESET_PC`, `HANDLER_PC`, `IM_BASE`, `IM_END`. CP0 and the other stages' exception checks reuse them.
- One sub-module, `fetch_addr_check`: combinational alignment and range check. Input is a 32-bit address plus the `IM_BASE`/`IM_END` parameters; output is an error bit. The D-stage jump-target check instantiates it too.
- The next-PC mux and the PC register stay in `fetch_pc`.

## Test plan
- Reset then 3 free-running cycles → `F_PC` = `3000`, `3004`, `3008`, `300C`; `F_ExcCode = 0`; `F_Instr` mirrors `IM_RData`.
- At PC `3010`: `D_Redirect = 1`, `D_Target = 3100`, `STALL_EN_N = 1` for 2 cycles, then 0 → `F_PC` holds `3010` for 2 cycles, then becomes `3100`.
- At PC `3020`: `Req` together with `ERET` (`EPC = 3008`) and `STALL_EN_N = 1` → next `F_PC = 4180`, `F_BD = 0` in the request cycle.
- `ERET` with `EPC = 3006` → `F_PC = 3006`, `F_ExcCode = 4`, `F_Instr = 0`. Next cycle: `F_PC = 300A`, still AdEL.
- Free-run from `6FF8` → `6FFC` is legal; `7000` gives `F_ExcCode = 4`. Separately, a redirect to `2FFC` gives AdEL.
- `D_IsBranchJump = 1` at PC `3040` → `F_BD = 1`. With `Req = 1` in the same cycle → `F_BD = 0`.
